// File: rtl/divisor_sequenciador.sv
// Sequencer for the unsigned restoring divider: one shift-subtract step per clock,
// result and divide-by-zero flag registered on entry to DONE.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation held
// CALC  | WIDTH shift-subtract iterations, one per clock
// DONE  | done pulse for one cycle; results valid
module divisor_sequenciador #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] saida,
    output logic [WIDTH-1:0] saidaResto
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH:0]   rem_q, rem_nxt;
    logic [WIDTH-1:0] quo_q, quo_nxt;
    logic [WIDTH-1:0] dvs_q, dvs_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [WIDTH-1:0] saida_nxt, resto_nxt;
    logic             dz_nxt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            saida      <= '0;
            saidaResto <= '0;
            div_zero   <= 1'b0;
        end else begin
            state      <= state_nxt;
            rem_q      <= rem_nxt;
            quo_q      <= quo_nxt;
            dvs_q      <= dvs_nxt;
            cnt_q      <= cnt_nxt;
            saida      <= saida_nxt;
            saidaResto <= resto_nxt;
            div_zero   <= dz_nxt;
        end
    end

    // Trial subtraction is WIDTH+1 bits; the MSB is the borrow (negative result).
    always_comb begin
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            rem_step = trial;
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = shifted;
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem_q;
        quo_nxt   = quo_q;
        dvs_nxt   = dvs_q;
        cnt_nxt   = cnt_q;
        saida_nxt = saida;
        resto_nxt = saidaResto;
        dz_nxt    = div_zero;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    dvs_nxt = divisor;
                    if (divisor != '0) begin
                        rem_nxt   = '0;
                        quo_nxt   = dividendo;
                        cnt_nxt   = '0;
                        state_nxt = CALC;
                    end else begin
                        saida_nxt = '1;
                        resto_nxt = dividendo;
                        dz_nxt    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            CALC: begin
                rem_nxt = rem_step;
                quo_nxt = quo_step;
                cnt_nxt = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    saida_nxt = quo_step;
                    resto_nxt = rem_step[WIDTH-1:0];
                    dz_nxt    = 1'b0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_divisor_sequenciador.sv
// Directed bench for divisor_sequenciador: table of operand/result vectors plus
// hand-written sequences for ignored start, mid-run reset and back-to-back starts.
module tb_divisor_sequenciador;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividendo = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] saida, saidaResto;

    int nvec = 0;
    int nmis = 0;
    logic [W-1:0] prev_q = '0;
    logic [W-1:0] prev_r = '0;

    divisor_sequenciador #(.WIDTH(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividendo(dividendo), .divisor(divisor),
        .busy(busy), .done(done), .div_zero(div_zero),
        .saida(saida), .saidaResto(saidaResto)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Cycles are counted in negedge samples after the accepting edge: the sample right
    // after the accept edge is 1, so a normal result shows done at 17, div-by-zero at 1.
    task automatic wait_done(input int limit, output int cycles);
        cycles = 1;
        while (!done && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        if (!done) begin
            nvec++;
            nmis++;
            $display("FAIL timeout: no done within %0d cycles", limit);
        end
    endtask

    task automatic run_op(input vec_t v);
        int cyc;
        @(negedge clk);
        dividendo = v.a;
        divisor   = v.b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        dividendo = 16'hA5A5;
        divisor   = 16'h0003;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        if (v.b != 0) begin
            chk("saida_held_in_calc", {16'd0, saida}, {16'd0, prev_q});
            chk("resto_held_in_calc", {16'd0, saidaResto}, {16'd0, prev_r});
        end
        wait_done(40, cyc);
        chk("latency", cyc, (v.b == 0) ? 32'd1 : 32'd17);
        chk("saida", {16'd0, saida}, {16'd0, v.q});
        chk("saidaResto", {16'd0, saidaResto}, {16'd0, v.r});
        chk("div_zero", {31'd0, div_zero}, {31'd0, v.dz});
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_cleared", {31'd0, busy}, 32'd0);
        chk("saida_hold_idle", {16'd0, saida}, {16'd0, v.q});
        prev_q = v.q;
        prev_r = v.r;
    endtask

    initial begin
        int cyc;
        int t1, t2, extra;
        vec_t v;

        tbl[0]  = '{16'd100,   16'd7,      16'd14,     16'd2,  1'b0};
        tbl[1]  = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,  1'b0};
        tbl[2]  = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,  1'b0};
        tbl[3]  = '{16'd3,     16'd10,     16'd0,      16'd3,  1'b0};
        tbl[4]  = '{16'd5,     16'd0,      16'hFFFF,   16'd5,  1'b1};
        tbl[5]  = '{16'd9,     16'd3,      16'd3,      16'd0,  1'b0};
        tbl[6]  = '{16'd1000,  16'd3,      16'd333,    16'd1,  1'b0};
        tbl[7]  = '{16'd0,     16'd5,      16'd0,      16'd0,  1'b0};
        tbl[8]  = '{16'h8000,  16'd3,      16'd10922,  16'd2,  1'b0};
        tbl[9]  = '{16'd12345, 16'd123,    16'd100,    16'd45, 1'b0};
        tbl[10] = '{16'd0,     16'd0,      16'hFFFF,   16'd0,  1'b1};

        // Reset state
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
        chk("rst_saida", {16'd0, saida}, 32'd0);
        chk("rst_resto", {16'd0, saidaResto}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_op(tbl[i]);

        // start pulsed at E5 of a 100/7 run must be ignored
        @(negedge clk);
        dividendo = 16'd100; divisor = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        dividendo = 16'd50; divisor = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 6;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("ign_latency", cyc, 32'd17);
        chk("ign_saida", {16'd0, saida}, 32'd14);
        chk("ign_resto", {16'd0, saidaResto}, 32'd2);
        extra = 0;
        repeat (24) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("ign_no_second_done", extra, 32'd0);
        chk("ign_saida_kept", {16'd0, saida}, 32'd14);

        // reset mid-run of 1000/3
        @(negedge clk);
        dividendo = 16'd1000; divisor = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_saida", {16'd0, saida}, 32'd0);
        chk("abort_resto", {16'd0, saidaResto}, 32'd0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) extra++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("abort_no_done", extra, 32'd0);
        prev_q = '0;
        prev_r = '0;
        v = '{16'd1000, 16'd3, 16'd333, 16'd1, 1'b0};
        run_op(v);

        // back-to-back with start held high: 40/6 twice
        @(negedge clk);
        dividendo = 16'd40; divisor = 16'd6; start = 1'b1;
        @(negedge clk);
        wait_done(40, t1);
        chk("b2b_saida_1", {16'd0, saida}, 32'd6);
        chk("b2b_resto_1", {16'd0, saidaResto}, 32'd4);
        @(negedge clk);
        t2 = t1 + 1;
        while (!done && t2 < t1 + 40) begin
            @(negedge clk);
            t2++;
        end
        start = 1'b0;
        chk("b2b_spacing", t2 - t1, 32'd18);
        chk("b2b_saida_2", {16'd0, saida}, 32'd6);
        chk("b2b_resto_2", {16'd0, saidaResto}, 32'd4);
        repeat (3) @(negedge clk);
        chk("b2b_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
